// File: rtl/spi_pkg.sv
// Shared types for the SPI command sequencer: default widths, FSM encoding
// and the packed command word layout {rw, addr, wdata}.
package spi_pkg;

    localparam int ADDR_WIDTH_DEF = 6;
    localparam int DATA_WIDTH_DEF = 20;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_ACK  = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_RESP      = 3'd4
    } seq_state_t;

    typedef struct packed {
        logic                      rw;
        logic [ADDR_WIDTH_DEF-1:0] addr;
        logic [DATA_WIDTH_DEF-1:0] wdata;
    } spi_cmd_t;

    function automatic int cmd_width(input int aw, input int dw);
        return 1 + aw + dw;
    endfunction

endpackage

// File: rtl/spi_cmd_fifo.sv
// Synchronous command FIFO; pointers carry one wrap bit so full and empty
// are distinguished without a separate counter.
module spi_cmd_fifo #(
    parameter int WIDTH = 27,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk_sys,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_din,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = i_push && !o_full;
    assign do_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is not reset; occupancy is defined solely by the pointers.
    always_ff @(posedge i_clk_sys) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= i_din;
    end

    assign o_dout  = mem[rd_ptr[AW-1:0]];
    assign o_empty = (wr_ptr == rd_ptr);
    assign o_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign o_level = wr_ptr - rd_ptr;

endmodule

// File: rtl/spi_cmd_sequencer.sv
// Buffers SPI read/write commands and issues them one at a time to the SPI
// controller, returning read data and flagging hung transfers.
module spi_cmd_sequencer
    import spi_pkg::*;
#(
    parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          i_clk_sys,
    input  logic                          i_rst_n,
    input  logic                          i_cmd_valid,
    output logic                          o_cmd_ready,
    input  logic                          i_cmd_rw,
    input  logic [ADDR_WIDTH-1:0]         i_cmd_addr,
    input  logic [DATA_WIDTH-1:0]         i_cmd_wdata,
    output logic                          o_rsp_valid,
    input  logic                          i_rsp_ready,
    output logic [ADDR_WIDTH-1:0]         o_rsp_addr,
    output logic [DATA_WIDTH-1:0]         o_rsp_rdata,
    output logic                          o_rsp_err,
    output logic                          o_start,
    output logic                          o_rw,
    output logic [ADDR_WIDTH-1:0]         o_address,
    output logic [DATA_WIDTH-1:0]         o_write_data,
    input  logic [DATA_WIDTH-1:0]         i_ctrl_rdata,
    input  logic                          i_ctrl_ready,
    input  logic                          i_err_clr,
    output logic                          o_timeout_err,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

    localparam int CMD_W = cmd_width(ADDR_WIDTH, DATA_WIDTH);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    seq_state_t       state_q;
    seq_state_t       state_d;
    logic [CMD_W-1:0] fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             set_err;
    logic             cap_rsp;
    logic             cap_tmo;
    logic             tmo_hit;
    logic             cnt_en;
    logic [CNT_W-1:0] tmo_cnt;

    spi_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk_sys (i_clk_sys),
        .i_rst_n   (i_rst_n),
        .i_push    (i_cmd_valid),
        .i_pop     (pop),
        .i_din     ({i_cmd_rw, i_cmd_addr, i_cmd_wdata}),
        .o_dout    (fifo_dout),
        .o_full    (fifo_full),
        .o_empty   (fifo_empty),
        .o_level   (o_fifo_level)
    );

    assign o_cmd_ready = !fifo_full;
    assign o_busy      = (state_q != ST_IDLE) || !fifo_empty;
    assign tmo_hit     = (tmo_cnt == TMO_LAST);

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        set_err = 1'b0;
        cap_rsp = 1'b0;
        cap_tmo = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && i_ctrl_ready) begin
                    pop     = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT_ACK;
            ST_WAIT_ACK: begin
                if (!i_ctrl_ready) begin
                    state_d = ST_WAIT_DONE;
                end else if (tmo_hit) begin
                    set_err = 1'b1;
                    cap_tmo = o_rw;
                    state_d = o_rw ? ST_RESP : ST_IDLE;
                end
            end
            ST_WAIT_DONE: begin
                if (i_ctrl_ready) begin
                    cap_rsp = o_rw;
                    state_d = o_rw ? ST_RESP : ST_IDLE;
                end else if (tmo_hit) begin
                    set_err = 1'b1;
                    cap_tmo = o_rw;
                    state_d = o_rw ? ST_RESP : ST_IDLE;
                end
            end
            ST_RESP: begin
                if (i_rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The timeout counter restarts on every state change, so each handshake
    // phase gets its own full budget.
    assign cnt_en = ((state_q == ST_WAIT_ACK) || (state_q == ST_WAIT_DONE)) && (state_d == state_q);

    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= ST_IDLE;
            o_start       <= 1'b0;
            o_rw          <= 1'b0;
            o_address     <= '0;
            o_write_data  <= '0;
            o_rsp_valid   <= 1'b0;
            o_rsp_addr    <= '0;
            o_rsp_rdata   <= '0;
            o_rsp_err     <= 1'b0;
            o_timeout_err <= 1'b0;
            tmo_cnt       <= '0;
        end else begin
            state_q     <= state_d;
            o_start     <= (state_d == ST_ISSUE);
            o_rsp_valid <= (state_d == ST_RESP);
            tmo_cnt     <= cnt_en ? tmo_cnt + CNT_W'(1) : '0;
            if (pop) {o_rw, o_address, o_write_data} <= fifo_dout;
            if (cap_rsp) begin
                o_rsp_addr  <= o_address;
                o_rsp_rdata <= i_ctrl_rdata;
                o_rsp_err   <= 1'b0;
            end else if (cap_tmo) begin
                o_rsp_addr  <= o_address;
                o_rsp_rdata <= '0;
                o_rsp_err   <= 1'b1;
            end
            // A timeout in the same cycle as a clear request keeps the flag set.
            if (set_err) begin
                o_timeout_err <= 1'b1;
            end else if (i_err_clr) begin
                o_timeout_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Scoreboard bench for spi_cmd_sequencer with a small SPI controller model.
module tb_spi_cmd_sequencer;

    localparam int AW = 6;
    localparam int DW = 20;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_rw = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_ready = 1'b0;
    logic          err_clr = 1'b0;
    logic [DW-1:0] ctrl_rdata = '0;
    logic          ctrl_ready_m = 1'b1;
    logic          stall = 1'b0;
    logic          hang = 1'b0;
    logic          ctrl_ready;

    logic          cmd_ready, rsp_valid, rsp_err, start, rw, timeout_err, busy;
    logic [AW-1:0] rsp_addr, address;
    logic [DW-1:0] rsp_rdata, write_data;
    logic [2:0]    fifo_level;

    int            busy_len = 3;
    logic [DW-1:0] next_rdata = '0;
    int            n_checks = 0;
    int            n_fail = 0;

    typedef struct packed { logic rw; logic [AW-1:0] a; logic [DW-1:0] d; } iss_t;
    typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; logic e; } rsp_t;
    iss_t iss_q[$];
    rsp_t rsp_q[$];

    assign ctrl_ready = ctrl_ready_m && !stall;

    always #5 clk = ~clk;

    spi_cmd_sequencer #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)
    ) dut (
        .i_clk_sys(clk), .i_rst_n(rst_n),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_cmd_rw(cmd_rw), .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_addr(rsp_addr), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
        .o_start(start), .o_rw(rw), .o_address(address), .o_write_data(write_data),
        .i_ctrl_rdata(ctrl_rdata), .i_ctrl_ready(ctrl_ready),
        .i_err_clr(err_clr), .o_timeout_err(timeout_err),
        .o_busy(busy), .o_fifo_level(fifo_level)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
        end
    endtask

    // Controller model: ready drops the cycle after start, returns busy_len
    // cycles later with next_rdata; in hang mode ready never drops.
    initial begin : ctrl_model
        int  cnt;
        logic pend;
        cnt  = 0;
        pend = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                ctrl_ready_m = 1'b1;
                pend = 1'b0;
                cnt  = 0;
            end else begin
                if (pend) begin
                    pend = 1'b0;
                    if (!hang) begin
                        ctrl_ready_m = 1'b0;
                        cnt = busy_len;
                    end
                end else if (!ctrl_ready_m) begin
                    cnt--;
                    if (cnt <= 0) begin
                        ctrl_ready_m = 1'b1;
                        ctrl_rdata = next_rdata;
                    end
                end
                if (start) pend = 1'b1;
            end
        end
    end

    always @(negedge clk) begin : monitor
        iss_t ei;
        rsp_t er;
        if (rst_n) begin
            if (start) begin
                if (iss_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_start: got addr 0x%0h, required no issue", address);
                end else begin
                    ei = iss_q.pop_front();
                    check("issue_cmd", 64'({rw, address, write_data}), 64'(ei));
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (rsp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: got addr 0x%0h, required no response", rsp_addr);
                end else begin
                    er = rsp_q.pop_front();
                    check("rsp_data", 64'({rsp_addr, rsp_rdata, rsp_err}), 64'(er));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic r, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic exp_acc, input logic exp_issue);
        check("cmd_ready", 64'(cmd_ready), 64'(exp_acc));
        cmd_valid = 1'b1;
        cmd_rw    = r;
        cmd_addr  = a;
        cmd_wdata = d;
        if (exp_acc && exp_issue) iss_q.push_back({r, a, d});
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int maxc, input string name);
        int k;
        k = 0;
        while ((busy || !ctrl_ready) && k < maxc) begin
            tick();
            k++;
        end
        check(name, 64'(k < maxc), 64'(1));
    endtask

    task automatic wait_start(input int maxc, input string name);
        int k;
        k = 0;
        while (!start && k < maxc) begin
            tick();
            k++;
        end
        check(name, 64'(start), 64'(1));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_start"},   64'(start), 64'(0));
        check({tag, "_rw"},      64'(rw), 64'(0));
        check({tag, "_addr"},    64'(address), 64'(0));
        check({tag, "_wdata"},   64'(write_data), 64'(0));
        check({tag, "_rsp"},     64'({rsp_valid, rsp_addr, rsp_rdata, rsp_err}), 64'(0));
        check({tag, "_tmo"},     64'(timeout_err), 64'(0));
        check({tag, "_busy"},    64'(busy), 64'(0));
        check({tag, "_level"},   64'(fifo_level), 64'(0));
        check({tag, "_cmd_rdy"}, 64'(cmd_ready), 64'(1));
    endtask

    initial begin : stimulus
        int k;
        repeat (3) tick();
        check_reset_vals("reset");
        rst_n = 1'b1;
        tick();

        // Single write: start two cycles after the push, hold until done.
        push(1'b0, 6'h2A, 20'h5A5A5, 1'b1, 1'b1);
        check("w_start_n1", 64'(start), 64'(0));
        check("w_level_n1", 64'(fifo_level), 64'(1));
        tick();
        check("w_start_n2", 64'(start), 64'(1));
        check("w_hold", 64'({rw, address, write_data}), 64'({1'b0, 6'h2A, 20'h5A5A5}));
        tick();
        check("w_start_pulse", 64'(start), 64'(0));
        k = 0;
        while (busy && k < 50) begin
            check("w_hold_stable", 64'({address, write_data}), 64'({6'h2A, 20'h5A5A5}));
            tick();
            k++;
        end
        wait_idle(50, "w_done");

        // Read held by back-pressure; a queued write must wait for it.
        next_rdata = 20'hABCDE;
        rsp_ready  = 1'b0;
        rsp_q.push_back({6'h15, 20'hABCDE, 1'b0});
        push(1'b1, 6'h15, 20'h00000, 1'b1, 1'b1);
        push(1'b0, 6'h07, 20'h12345, 1'b1, 1'b1);
        k = 0;
        while (!rsp_valid && k < 50) begin
            tick();
            k++;
        end
        check("r_rsp_seen", 64'(rsp_valid), 64'(1));
        for (int i = 0; i < 5; i++) begin
            check("r_hold_rsp", 64'({rsp_valid, rsp_addr, rsp_rdata, rsp_err}),
                  64'({1'b1, 6'h15, 20'hABCDE, 1'b0}));
            check("r_no_start", 64'(start), 64'(0));
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        wait_idle(100, "r_done");

        // Stalled controller: fill FIFO, fifth push dropped, then drain in order.
        stall = 1'b1;
        push(1'b0, 6'h01, 20'h11111, 1'b1, 1'b1);
        check("f_level1", 64'(fifo_level), 64'(1));
        push(1'b0, 6'h02, 20'h22222, 1'b1, 1'b1);
        push(1'b0, 6'h03, 20'h33333, 1'b1, 1'b1);
        push(1'b0, 6'h04, 20'h44444, 1'b1, 1'b1);
        check("f_level4", 64'(fifo_level), 64'(4));
        push(1'b0, 6'h05, 20'h55555, 1'b0, 1'b1);
        check("f_level_drop", 64'(fifo_level), 64'(4));
        stall = 1'b0;
        wait_idle(300, "f_drain");

        // Hung controller on a read: timeout response and sticky flag.
        hang = 1'b1;
        rsp_ready = 1'b1;
        rsp_q.push_back({6'h3C, 20'h00000, 1'b1});
        push(1'b1, 6'h3C, 20'h00000, 1'b1, 1'b1);
        wait_start(10, "t_start");
        k = 0;
        while (!timeout_err && k < 40) begin
            tick();
            k++;
        end
        n_checks++;
        if (!(k == 16 || k == 17)) begin
            n_fail++;
            $display("FAIL t_latency: got %0d cycles after issue, required 16..17", k);
        end
        wait_idle(50, "t_done");
        check("t_sticky", 64'(timeout_err), 64'(1));
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t_cleared", 64'(timeout_err), 64'(0));
        hang = 1'b0;

        // Reset during WAIT_DONE with two commands queued.
        busy_len = 30;
        push(1'b1, 6'h01, 20'h00000, 1'b1, 1'b1);
        wait_start(10, "x_start");
        repeat (4) tick();
        push(1'b0, 6'h0A, 20'hAAAAA, 1'b1, 1'b0);
        push(1'b0, 6'h0B, 20'hBBBBB, 1'b1, 1'b0);
        check("x_level2", 64'(fifo_level), 64'(2));
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("xrst");
        tick();
        tick();
        rst_n = 1'b1;
        repeat (60) tick();
        check("x_level_after", 64'(fifo_level), 64'(0));
        check("x_busy_after", 64'(busy), 64'(0));
        check("x_rsp_after", 64'(rsp_valid), 64'(0));

        check("iss_q_empty", 64'(iss_q.size()), 64'(0));
        check("rsp_q_empty", 64'(rsp_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/spi_cmd_sequencer.md
# spi_cmd_sequencer

Command sequencer that sits directly upstream of `SPI_Controller`. It buffers read/write commands from the PoolCache side in a small FIFO and issues them one at a time over the controller's `start`/`rw`/`address`/`write_data` interface. It tracks each transfer to completion using the controller's ready/valid flag, returns read data through a valid/ready response port, and flags hung transfers with a timeout.

## Interface
Parameters:
- ADDR_WIDTH, 6, SPI address width; matches controller SPI_ADDR_WIDTH
- DATA_WIDTH, 20, SPI data width; matches controller SPI_DATA_WIDTH
- FIFO_DEPTH, 4, command FIFO entries; power of 2, ≥2
- TIMEOUT_CYCLES, 1024, i_clk_sys cycles allowed per handshake phase before abort

Ports:
- i_clk_sys  in  1  system clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_cmd_valid  in  1  command push request
- o_cmd_ready  out  1  FIFO not full
- i_cmd_rw  in  1  0 = write, 1 = read
- i_cmd_addr  in  ADDR_WIDTH  command address
- i_cmd_wdata  in  DATA_WIDTH  write data; ignored for reads
- o_rsp_valid  out  1  read response available
- i_rsp_ready  in  1  response consumed
- o_rsp_addr  out  ADDR_WIDTH  address of the read
- o_rsp_rdata  out  DATA_WIDTH  read data; 0 on timeout
- o_rsp_err  out  1  response was aborted by timeout
- o_start  out  1  to controller i_start
- o_rw  out  1  to controller i_rw
- o_address  out  ADDR_WIDTH  to controller i_address
- o_write_data  out  DATA_WIDTH  to controller i_write_data
- i_ctrl_rdata  in  DATA_WIDTH  from controller o_read_data
- i_ctrl_ready  in  1  from controller o_data_valid; high means idle
- i_err_clr  in  1  clears o_timeout_err
- o_timeout_err  out  1  sticky timeout flag
- o_busy  out  1  state ≠ IDLE or FIFO non-empty
- o_fifo_level  out  $clog2(FIFO_DEPTH)+1  occupied entries

## Operation
- **Push.** A command is written when `i_cmd_valid && o_cmd_ready`. `o_cmd_ready = !full`. There is no same-cycle bypass, so a command pushed into an empty FIFO is visible next cycle. A push and a pop in the same cycle leave the level unchanged. A push while full is ignored; the bench checks that nothing is overwritten.
- **FSM states:** IDLE, ISSUE, WAIT_ACK, WAIT_DONE, RESP.
- **IDLE.** If the FIFO is non-empty and `i_ctrl_ready` = 1: pop the head into the hold registers (`o_rw`, `o_address`, `o_write_data`) and go to ISSUE.
- **ISSUE.** `o_start` = 1 for exactly this one cycle. Go to WAIT_ACK and clear the timeout counter.
- **WAIT_ACK.** On `i_ctrl_ready` = 0, go to WAIT_DONE and clear the counter.
- **WAIT_DONE.** On `i_ctrl_ready` = 1:
  - read: capture `i_ctrl_rdata` and `o_address` into the response registers, set `o_rsp_err` = 0, go to RESP;
  - write: go to IDLE.
- **RESP.** `o_rsp_valid` = 1, held stable until `i_rsp_ready` = 1, then go to IDLE. The next command is not issued until the response is consumed.
- **Timeout.** The counter runs in WAIT_ACK and WAIT_DONE. When it reaches TIMEOUT_CYCLES-1 without the awaited edge:
  - set `o_timeout_err`;
  - read: go to RESP with `o_rsp_rdata` = 0 and `o_rsp_err` = 1;
  - write: go to IDLE.
- **Error flag.** `o_timeout_err` is sticky. `i_err_clr` clears it. If set and clear occur in the same cycle, set wins.
- **Hold stability.** `o_rw`, `o_address` and `o_write_data` stay stable from ISSUE until the FSM returns to IDLE. The controller samples address/data one cycle after start and uses rw for the whole transfer.
- **Reset.** Asynchronous reset at any point, including mid-transfer, empties the FIFO and returns the FSM to IDLE. No partial response is emitted.

## Timing
- Reset values: `o_start` 0, `o_rw` 0, `o_address` 0, `o_write_data` 0, `o_rsp_valid` 0, `o_rsp_addr` 0, `o_rsp_rdata` 0, `o_rsp_err` 0, `o_timeout_err` 0, `o_busy` 0, `o_fifo_level` 0, `o_cmd_ready` 1.
- All outputs are registered except `o_cmd_ready`, `o_busy` and `o_fifo_level`, which decode registered state.
- Push to `o_start` on an idle, empty system: push at cycle N, pop at N+1, `o_start` high at N+2.
- `i_ctrl_ready` is expected to fall the cycle after ISSUE, because the controller registers its valid flag.
- Read completion: `o_rsp_valid` rises one cycle after `i_ctrl_ready` rises.
- Back-to-back writes: the next pop occurs in the cycle after the FSM returns to IDLE, provided `i_ctrl_ready` = 1.

## Structure
- **Package `spi_pkg`:** ADDR_WIDTH/DATA_WIDTH defaults, the FSM state encoding (3 bits), and the packed command layout {rw, addr, wdata}, width 1+ADDR_WIDTH+DATA_WIDTH.
- **Sub-module `spi_cmd_fifo`:** synchronous FIFO with registered pointers, full/empty/level outputs and width = packed command width.
- The sequencer FSM, hold registers, response registers and timeout counter live in the top module.

## Test plan
- Reset, then push write {addr=0x2A, data=0x5A5A5} → `o_start` pulses exactly once at push+2; `o_address`=0x2A and `o_write_data`=0x5A5A5 held until `i_ctrl_ready` returns; no response is emitted.
- Push read addr=0x15; the controller model returns 0xABCDE → `o_rsp_valid`=1, `o_rsp_addr`=0x15, `o_rsp_rdata`=0xABCDE, `o_rsp_err`=0; hold `i_rsp_ready`=0 for 5 cycles → outputs stay stable and no new `o_start`.
- Push 5 commands with FIFO_DEPTH=4 and the controller stalled → `o_cmd_ready`=0 after the 4th, the 5th push is dropped, `o_fifo_level`=4; release the controller → 4 transfers issue in order.
- Controller model never drops ready after start, TIMEOUT_CYCLES=16, read command → `o_timeout_err` sets 16 cycles after ISSUE, response has `o_rsp_err`=1 and `o_rsp_rdata`=0; `i_err_clr` clears the flag.
- Assert `i_rst_n` low during WAIT_DONE with 2 commands queued → all outputs return to their reset values, `o_fifo_level`=0, and no response appears after release.
